// File: rtl/parallel_to_serial.sv
// Word-to-bitstream serializer: valid/ready word load, then one bit per clock, LSB- or MSB-first.
// Optional even-parity bit after the data bits when P2S_PARITY_EN is defined.
module parallel_to_serial #(
    parameter int DATA_WIDTH = 4,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] parallel_data,
    input  logic                  load,
    output logic                  load_ready,
    output logic                  serial_data,
    output logic                  serial_valid,
    output logic                  serial_last,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
`ifdef P2S_PARITY_EN
        PARITY,
`endif
        SHIFT
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] sr;
    logic [CW-1:0]         cnt;
    logic                  accept;
`ifdef P2S_PARITY_EN
    logic                  par;
`endif

    // serial_last is high exactly on the frame's final bit, so it doubles as the
    // "can take the next word" condition for back-to-back streaming.
    assign load_ready = !reset && (state == IDLE || serial_last);
    assign accept     = load && load_ready;
    assign busy       = serial_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sr           <= '0;
            cnt          <= '0;
            serial_data  <= 1'b0;
            serial_valid <= 1'b0;
            serial_last  <= 1'b0;
`ifdef P2S_PARITY_EN
            par          <= 1'b0;
`endif
        end else if (accept) begin
            // sr holds the not-yet-sent bits; the first bit goes straight to the output.
            state        <= SHIFT;
            cnt          <= '0;
            serial_valid <= 1'b1;
            serial_last  <= 1'b0;
`ifdef P2S_PARITY_EN
            par          <= ^parallel_data;
`endif
            if (LSB_FIRST) begin
                sr          <= parallel_data >> 1;
                serial_data <= parallel_data[0];
            end else begin
                sr          <= parallel_data << 1;
                serial_data <= parallel_data[DATA_WIDTH-1];
            end
        end else begin
            case (state)
                SHIFT: begin
                    if (cnt != CW'(DATA_WIDTH - 1)) begin
                        cnt <= cnt + CW'(1);
`ifdef P2S_PARITY_EN
                        serial_last <= 1'b0;
`else
                        serial_last <= (cnt == CW'(DATA_WIDTH - 2));
`endif
                        if (LSB_FIRST) begin
                            sr          <= sr >> 1;
                            serial_data <= sr[0];
                        end else begin
                            sr          <= sr << 1;
                            serial_data <= sr[DATA_WIDTH-1];
                        end
                    end else begin
`ifdef P2S_PARITY_EN
                        state       <= PARITY;
                        cnt         <= CW'(DATA_WIDTH);
                        serial_data <= par;
                        serial_last <= 1'b1;
`else
                        state        <= IDLE;
                        cnt          <= '0;
                        sr           <= '0;
                        serial_data  <= 1'b0;
                        serial_valid <= 1'b0;
                        serial_last  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state        <= IDLE;
                    cnt          <= '0;
                    sr           <= '0;
                    serial_data  <= 1'b0;
                    serial_valid <= 1'b0;
                    serial_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Scoreboard bench: LSB-first and MSB-first instances driven in parallel; bits checked on negedge.
module tb_parallel_to_serial;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] pd = '0;
    logic       load = 1'b0;
    logic       ready_a, d_a, v_a, l_a, busy_a;
    logic       ready_b, d_b, v_b, l_b, busy_b;

    int checks = 0;
    int errors = 0;
    logic [1:0] q_a[$];
    logic [1:0] q_b[$];

`ifdef P2S_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    parallel_to_serial #(.DATA_WIDTH(4), .LSB_FIRST(1'b1)) dut_a (
        .clk(clk), .reset(reset), .parallel_data(pd), .load(load), .load_ready(ready_a),
        .serial_data(d_a), .serial_valid(v_a), .serial_last(l_a), .busy(busy_a));

    parallel_to_serial #(.DATA_WIDTH(4), .LSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(reset), .parallel_data(pd), .load(load), .load_ready(ready_b),
        .serial_data(d_b), .serial_valid(v_b), .serial_last(l_b), .busy(busy_b));

    always #5 clk = ~clk;

    // Expected entries are {bit, last}; an empty queue means the line must be idle.
    always @(negedge clk) begin : monitor
        logic       er;
        logic [1:0] ea, eb;
        er = !reset && (q_a.size() == 0 || q_a[0][0]);
        checks++;
        if (ready_a !== er || ready_b !== er) begin
            errors++;
            $display("FAIL load_ready got a=%b b=%b expected %b", ready_a, ready_b, er);
        end
        checks++;
        if (q_a.size() != 0) begin
            ea = q_a.pop_front();
            if ({v_a, d_a, l_a} !== {1'b1, ea}) begin
                errors++;
                $display("FAIL lsb_bit got v/d/l=%b%b%b expected 1%b", v_a, d_a, l_a, ea);
            end
        end else if ({v_a, d_a, l_a} !== 3'b000) begin
            errors++;
            $display("FAIL lsb_idle got v/d/l=%b%b%b expected 000", v_a, d_a, l_a);
        end
        checks++;
        if (q_b.size() != 0) begin
            eb = q_b.pop_front();
            if ({v_b, d_b, l_b} !== {1'b1, eb}) begin
                errors++;
                $display("FAIL msb_bit got v/d/l=%b%b%b expected 1%b", v_b, d_b, l_b, eb);
            end
        end else if ({v_b, d_b, l_b} !== 3'b000) begin
            errors++;
            $display("FAIL msb_idle got v/d/l=%b%b%b expected 000", v_b, d_b, l_b);
        end
        checks++;
        if (busy_a !== v_a || busy_b !== v_b) begin
            errors++;
            $display("FAIL busy got a=%b b=%b expected a=%b b=%b", busy_a, busy_b, v_a, v_b);
        end
    end

    task automatic push_word(input logic [3:0] w);
        for (int i = 0; i < 4; i++) begin
            q_a.push_back({w[i], (i == 3) && !PAR});
            q_b.push_back({w[3-i], (i == 3) && !PAR});
        end
        if (PAR) begin
            q_a.push_back({^w, 1'b1});
            q_b.push_back({^w, 1'b1});
        end
    endtask

    // Called just after a posedge; holds load until accepted, returns just after the accepting edge.
    task automatic send(input logic [3:0] w);
        bit accepted = 1'b0;
        load = 1'b1;
        pd   = w;
        for (int c = 0; c < 50 && !accepted; c++) begin
            @(negedge clk);
            #4;
            if (ready_a) begin
                push_word(w);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        load = 1'b0;
        checks++;
        if (!accepted) begin
            errors++;
            $display("FAIL send_timeout word=%h got accepted=0 expected 1", w);
        end
    endtask

    task automatic drain();
        int c = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && c < 40) begin
            @(posedge clk);
            c++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got pending=%0d expected 0", q_a.size());
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        load = 1'b1;
        pd   = 4'hF;
        @(negedge clk);
        checks++;
        if ({d_a, v_a, l_a, busy_a, ready_a} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b expected 00000", {d_a, v_a, l_a, busy_a, ready_a});
        end
        @(posedge clk);
        #1;
        checks++;
        if (v_a !== 1'b0 || v_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_load_ignored got valid=%b%b expected 00", v_a, v_b);
        end
        reset = 1'b0;
        load  = 1'b0;
        @(negedge clk);
        checks++;
        if (ready_a !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b expected 1", ready_a);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        send(4'b1011);
        drain();
        send(4'b0011);
        drain();
    endtask

    task automatic test_back_to_back();
        send(4'hA);
        send(4'h5);
        drain();
    endtask

    task automatic test_hold();
        send(4'h0);
        send(4'hF);
        drain();
    endtask

    task automatic test_mid_reset();
        send(4'b1011);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        q_a.delete();
        q_b.delete();
        checks++;
        if ({v_a, d_a, l_a, v_b, d_b, l_b} !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset got %b expected 000000", {v_a, d_a, l_a, v_b, d_b, l_b});
        end
        reset = 1'b0;
        send(4'b0110);
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_hold();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/parallel_to_serial.md
# parallel_to_serial

Word-to-bitstream serializer (PISO) that sits directly upstream of `serial_to_parallel` and drives its `serial_data` input. It accepts a parallel word through a valid/ready handshake, then shifts it out one bit per clock in LSB-first or MSB-first order. Back-to-back words stream with no idle gap, matching the downstream stage's free-running bit counter.

## Interface

Parameters:
- `DATA_WIDTH`, default 4: bits per word. Legal range is 2 or more.
- `LSB_FIRST`, default 1: 1 sends bit 0 first; 0 sends bit `DATA_WIDTH-1` first.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `parallel_data`  in  `DATA_WIDTH`  word to transmit; sampled only on an accepted load.
- `load`  in  1  upstream valid; `parallel_data` is presented.
- `load_ready`  out  1  block can accept a word this cycle.
- `serial_data`  out  1  current serial bit, registered.
- `serial_valid`  out  1  `serial_data` carries a frame bit this cycle.
- `serial_last`  out  1  the current bit is the final bit of the frame.
- `busy`  out  1  a frame is in progress.

## Operation

- Handshake: a word is accepted at a rising edge where `load && load_ready`. When `load` is high but `load_ready` is low, the word is ignored, no capture occurs, and upstream holds the word until it is accepted.
- State machine states:
  - IDLE: no frame in progress.
  - SHIFT: data bits are being sent.
  - PARITY: exists only with `P2S_PARITY_EN`.
- State transitions:
  - IDLE → SHIFT on an accepted load.
  - SHIFT stays in SHIFT while the bit counter is below `DATA_WIDTH-1`.
  - On the last data bit: SHIFT → PARITY when parity is enabled. Otherwise SHIFT → SHIFT if a new load is accepted, else SHIFT → IDLE.
  - PARITY → SHIFT on an accepted load, else PARITY → IDLE.
- On an accepted load, the word is captured into the shift register and the first bit is driven on `serial_data`.
- Shift direction:
  - `LSB_FIRST=1`: shift right and output `sr[0]`.
  - `LSB_FIRST=0`: shift left and output `sr[DATA_WIDTH-1]`.
- Bit counter: `$clog2(DATA_WIDTH+1)` bits wide. Cleared on load, incremented on each bit, never wraps past the frame length.
- `load_ready` is combinational and equals `!reset && (IDLE || final bit of the frame)`. The final bit is the last data bit, or the parity bit when parity is enabled.
- `busy` equals `serial_valid`.
- Idle outputs: `serial_data=0`, `serial_valid=0`, `serial_last=0`.
- Reset mid-frame: the frame is aborted and the partial word is discarded. The next frame starts from bit 0 after the next accepted load.

## Timing

- Reset values: `serial_data=0`, `serial_valid=0`, `serial_last=0`, `busy=0`, state IDLE, counter 0, shift register 0.
- `load_ready` is 0 while `reset` is high and 1 in the first cycle after reset is released.
- Load accepted at edge N:
  - bit 0 of the frame is valid from edge N to edge N+1, so the downstream stage samples it at edge N+1;
  - bit k is valid from edge N+k to edge N+k+1;
  - `serial_last` is high for bit `DATA_WIDTH-1`, or for the parity bit when parity is enabled.
- Latency: one cycle from load acceptance to the first bit.
- Frame length: `DATA_WIDTH` cycles, or `DATA_WIDTH+1` with parity.
- Back-to-back: a load accepted at the end of the final-bit cycle puts bit 0 of the next word out at the following edge. There is no gap and `serial_valid` stays high.
- `reset` and `load` asserted together: reset wins and the word is not accepted.

## Configuration

- `P2S_PARITY_EN` defined:
  - one extra bit is appended after the data bits, equal to the XOR of the captured word (even parity);
  - `serial_last` and `load_ready` move from the last data bit to the parity bit;
  - frame length is `DATA_WIDTH+1`.
- `P2S_PARITY_EN` undefined:
  - the PARITY state and its logic are not compiled;
  - frames are exactly `DATA_WIDTH` bits.

## Test plan

- `LSB_FIRST=1`, load 4'b1011 -> `serial_data` is 1,1,0,1 over 4 cycles with `serial_last` on the 4th. A downstream `serial_to_parallel` with `LSB_FIRST=1` presents 4'b1011 with `data_ready`.
- `LSB_FIRST=0`, load 4'b1011 -> `serial_data` is 1,0,1,1 and the downstream stage with `LSB_FIRST=0` presents 4'b1011.
- 4'hA loaded, then 4'h5 loaded during the final-bit cycle -> 8 consecutive valid bits 0,1,0,1,1,0,1,0 with no gap. `load_ready` is high only in IDLE and on the two final-bit cycles.
- `load=1` with 4'hF held mid-frame while 4'h0 is shifting -> 4'hF is ignored, the 4'h0 bits are unchanged, and 4'hF is accepted on the final-bit cycle.
- `reset` asserted after 2 bits of 4'b1011 -> at the next edge all outputs are 0 and the state is IDLE. A fresh load of 4'b0110 sends 0,1,1,0 (LSB first) from bit 0.
- `P2S_PARITY_EN` defined, load 4'b1011 -> the stream is 1,1,0,1 then parity 1, with `serial_last` on the 5th bit. Load 4'b0011 -> parity 0.
